snn_in_buf: RTL and testbench

- Input-capture and window-fetch stage directly upstream of the Siamese-network convolution core.
- Absorbs the 48-cycle serial input frame: Img ×48, Kernel ×27, Weight ×4, Opt ×1.
- Then streams one padded 3×3 image window per output position, with the matching kernel, to the conv engine over a valid/ready handshake.
- Holds Weight and Opt static for the downstream FC and activation stages until the next frame.

---
 rtl/snn_pkg.sv | 35 +++
 rtl/snn_in_buf_if.sv | 22 ++
 rtl/snn_pad_window.sv | 31 +++
 rtl/snn_in_buf.sv | 195 +++++++++++++++++++
 tb/tb_snn_in_buf.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the Siamese-network input buffer: frame geometry,
// FSM states and the packed 3x3 window type handed to the conv engine.
package snn_pkg;

  localparam int DATA_W       = 32;
  localparam int IMG_SIDE     = 4;
  localparam int N_CH         = 3;
  localparam int K_SIDE       = 3;
  localparam int N_WGT        = 4;
  localparam int CH_WORDS     = IMG_SIDE * IMG_SIDE;
  localparam int KER_CH_WORDS = K_SIDE * K_SIDE;
  localparam int IMG_WORDS    = CH_WORDS * N_CH;
  localparam int KER_WORDS    = KER_CH_WORDS * N_CH;

  localparam int OPT_PAD_BIT  = 0;
  localparam int OPT_ACT_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Element (i,j) of a window lives at index K_SIDE*i+j, i.e. bits [DATA_W*(3i+j) +: DATA_W].
  typedef logic [KER_CH_WORDS-1:0][DATA_W-1:0] win_t;
  typedef logic [CH_WORDS-1:0][DATA_W-1:0]     chan_t;

  function automatic int clamp_coord(input int v);
    if (v < 0)             return 0;
    else if (v >= IMG_SIDE) return IMG_SIDE - 1;
    else                   return v;
  endfunction

endpackage

// File: rtl/snn_in_buf_if.sv
// Window stream from the input buffer to the conv engine (valid/ready handshake).
interface snn_in_buf_if;
  import snn_pkg::*;

  logic       win_valid;
  logic       win_ready;
  win_t       win_data;
  win_t       win_ker;
  logic [1:0] win_ch;
  logic [3:0] win_pos;
  logic       win_last;

  modport master (
    output win_valid, win_data, win_ker, win_ch, win_pos, win_last,
    input  win_ready
  );

  modport slave (
    input  win_valid, win_data, win_ker, win_ch, win_pos, win_last,
    output win_ready
  );
endinterface

// File: rtl/snn_pad_window.sv
// Combinational 3x3 window extraction around (row, col) of one 4x4 channel,
// with replicate (clamp) or zero padding at the image border.
module snn_pad_window
  import snn_pkg::*;
(
  input  chan_t      chan,
  input  logic [1:0] row,
  input  logic [1:0] col,
  input  logic       zero_pad,
  output win_t       win
);

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can infer a latch.
    win = '0;
    for (int i = 0; i < K_SIDE; i++) begin
      for (int j = 0; j < K_SIDE; j++) begin
        int   rr;
        int   cc;
        logic oob;
        logic [3:0] pix;
        rr  = int'(row) + i - 1;
        cc  = int'(col) + j - 1;
        oob = (rr < 0) || (rr >= IMG_SIDE) || (cc < 0) || (cc >= IMG_SIDE);
        pix = 4'(IMG_SIDE * clamp_coord(rr) + clamp_coord(cc));
        win[K_SIDE*i+j] = (oob && zero_pad) ? '0 : chan[pix];
      end
    end
  end

endmodule

// File: rtl/snn_in_buf.sv
// Captures one 48-cycle serial frame (image, kernels, FC weights, mode) and then
// streams 48 padded 3x3 windows with their channel kernel to the conv engine.
module snn_in_buf
  import snn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       Img,
  input  logic [DATA_W-1:0]       Kernel,
  input  logic [DATA_W-1:0]       Weight,
  input  logic [1:0]              Opt,
  snn_in_buf_if.master            win,
  output logic [N_WGT*DATA_W-1:0] wgt_out,
  output logic [1:0]              opt_out,
  output logic                    frame_done
);

  localparam logic [5:0] LAST_WORD = 6'(IMG_WORDS - 1);

  // Frame storage
  logic [DATA_W-1:0] img_mem [N_CH][CH_WORDS];
  logic [DATA_W-1:0] ker_mem [KER_WORDS];

  // State and registered outputs
  state_e                        state_q,      state_d;
  logic [5:0]                    cnt_q,        cnt_d;
  logic [5:0]                    widx_q,       widx_d;
  logic                          win_valid_q,  win_valid_d;
  logic                          win_last_q,   win_last_d;
  win_t                          win_data_q,   win_data_d;
  win_t                          win_ker_q,    win_ker_d;
  logic [N_WGT-1:0][DATA_W-1:0]  wgt_q,        wgt_d;
  logic [1:0]                    opt_q,        opt_d;
  logic                          frame_done_q, frame_done_d;

  logic [5:0] cap_idx;
  logic [5:0] sel_idx;
  logic       load_win;
  chan_t      sel_chan;
  win_t       pad_win;
  win_t       ker_win;

  // Any in_valid cycle outside LOAD starts a fresh frame at word 0.
  assign cap_idx = (state_q == LOAD) ? cnt_q : '0;

  // Window to load next: the first one when capture completes, else the successor.
  always_comb begin
    sel_idx = '0;
    if (state_q == EMIT && widx_q != LAST_WORD) begin
      sel_idx = widx_q + 6'd1;
    end
  end

  always_comb begin
    sel_chan = '0;
    ker_win  = '0;
    for (int k = 0; k < CH_WORDS; k++) begin
      sel_chan[k] = img_mem[sel_idx[5:4]][k];
    end
    for (int e = 0; e < KER_CH_WORDS; e++) begin
      ker_win[e] = ker_mem[5'(KER_CH_WORDS * int'(sel_idx[5:4]) + e)];
    end
  end

  snn_pad_window u_pad_window (
    .chan     (sel_chan),
    .row      (sel_idx[3:2]),
    .col      (sel_idx[1:0]),
    .zero_pad (opt_q[OPT_PAD_BIT]),
    .win      (pad_win)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    win_data_d   = win_data_q;
    win_ker_d    = win_ker_q;
    wgt_d        = wgt_q;
    opt_d        = opt_q;
    frame_done_d = 1'b0;
    load_win     = 1'b0;

    if (in_valid) begin
      if (cap_idx < 6'(N_WGT)) wgt_d[cap_idx[1:0]] = Weight;
      if (cap_idx == '0)       opt_d = Opt;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
          cnt_d   = 6'd1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (cnt_q == LAST_WORD) begin
            state_d     = EMIT;
            cnt_d       = '0;
            widx_d      = '0;
            win_valid_d = 1'b1;
            win_last_d  = 1'b0;
            load_win    = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      EMIT: begin
        // A new frame overrides the handshake: the partial stream is abandoned.
        if (in_valid) begin
          state_d     = LOAD;
          cnt_d       = 6'd1;
          win_valid_d = 1'b0;
          win_last_d  = 1'b0;
        end else if (win_valid_q && win.win_ready) begin
          if (win_last_q) begin
            state_d      = DONE;
            win_valid_d  = 1'b0;
            win_last_d   = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            widx_d     = widx_q + 6'd1;
            win_last_d = (widx_q + 6'd1 == LAST_WORD);
            load_win   = 1'b1;
          end
        end
      end
      DONE: begin
        if (in_valid) begin
          state_d = LOAD;
          cnt_d   = 6'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_win) begin
      win_data_d = pad_win;
      win_ker_d  = ker_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      widx_q       <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      win_data_q   <= '0;
      win_ker_q    <= '0;
      wgt_q        <= '0;
      opt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      win_data_q   <= win_data_d;
      win_ker_q    <= win_ker_d;
      wgt_q        <= wgt_d;
      opt_q        <= opt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: storage arrays are left unreset; every word is written before any window reads it.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      img_mem[cap_idx[5:4]][cap_idx[3:0]] <= Img;
      if (cap_idx < 6'(KER_WORDS)) ker_mem[cap_idx[4:0]] <= Kernel;
    end
  end

  assign win.win_valid = win_valid_q;
  assign win.win_data  = win_data_q;
  assign win.win_ker   = win_ker_q;
  assign win.win_ch    = widx_q[5:4];
  assign win.win_pos   = widx_q[3:0];
  assign win.win_last  = win_last_q;
  assign wgt_out       = wgt_q;
  assign opt_out       = opt_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_snn_in_buf.sv
// Directed scoreboard bench for snn_in_buf: expected windows are queued from a
// padding model when a frame is sent and popped on each handshake.
module tb_snn_in_buf;
  import snn_pkg::*;

  typedef struct {
    win_t       data;
    win_t       ker;
    logic [1:0] ch;
    logic [3:0] pos;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] Img, Kernel, Weight;
  logic [1:0]  Opt;
  logic [127:0] wgt_out;
  logic [1:0]  opt_out;
  logic        frame_done;

  snn_in_buf_if w_if ();

  snn_in_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .Img        (Img),
    .Kernel     (Kernel),
    .Weight     (Weight),
    .Opt        (Opt),
    .win        (w_if),
    .wgt_out    (wgt_out),
    .opt_out    (opt_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   fd_count = 0;
  exp_t sb[$];

  always @(posedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic win_t model_win(input logic [31:0] base, input int ch, input int pos, input bit zero);
    win_t w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr;
        int cc;
        rr = pos / 4 + i - 1;
        cc = pos % 4 + j - 1;
        if (rr < 0 || rr > 3 || cc < 0 || cc > 3) begin
          if (!zero) begin
            rr = (rr < 0) ? 0 : ((rr > 3) ? 3 : rr);
            cc = (cc < 0) ? 0 : ((cc > 3) ? 3 : cc);
            w[3*i+j] = base + 32'(ch*16 + rr*4 + cc);
          end
        end else begin
          w[3*i+j] = base + 32'(ch*16 + rr*4 + cc);
        end
      end
    end
    return w;
  endfunction

  function automatic win_t model_ker(input int ch);
    win_t k;
    for (int e = 0; e < 9; e++) k[e] = 32'h200 + 32'(ch*9 + e);
    return k;
  endfunction

  // Drives one 48-word frame (optionally with an in_valid gap after word 20) and
  // queues its 48 expected windows. Returns at the negedge where in_valid has dropped.
  task automatic send_frame(input logic [31:0] base, input logic [1:0] opt, input int gap);
    logic [127:0] exp_w;
    exp_t e;
    w_if.win_ready = 1'b0;
    for (int idx = 0; idx < 48; idx++) begin
      e.data = model_win(base, idx / 16, idx % 16, opt[0]);
      e.ker  = model_ker(idx / 16);
      e.ch   = 2'(idx / 16);
      e.pos  = 4'(idx % 16);
      e.last = (idx == 47);
      sb.push_back(e);
    end
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 1)  check("valid_low_in_load", w_if.win_valid, 1'b0);
      if (k == 47) check("valid_low_before_last", w_if.win_valid, 1'b0);
      in_valid = 1'b1;
      Img      = base + 32'(k);
      Kernel   = (k < 27) ? 32'h200 + 32'(k) : 32'hDEAD_0000 | 32'(k);
      Weight   = (k < 4)  ? 32'h300 + 32'(k) : 32'hBEEF_0000 | 32'(k);
      Opt      = (k == 0) ? opt : ~opt;
      if (k == 20) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          Img      = 32'hFFFF_FFFF;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    Img      = 32'hFFFF_FFFF;
    check("first_valid_latency", w_if.win_valid, 1'b1);
    for (int k = 0; k < 4; k++) exp_w[32*k +: 32] = 32'h300 + 32'(k);
    check("wgt_out", wgt_out, exp_w);
    check("opt_out", opt_out, opt);
  endtask

  // Consumes n_win windows against the scoreboard. bp enables backpressure.
  task automatic drain(input bit bp, input int n_win, input bit full);
    int   got       = 0;
    int   cyc       = 0;
    int   first_cyc = -1;
    int   last_cyc  = 0;
    bit   stalled   = 0;
    bit   rdy;
    logic [3:0] pat = 4'b1001;
    logic [583:0] held;
    logic [583:0] now_v;
    exp_t e;
    while (got < n_win && cyc < 4000) begin
      now_v = {w_if.win_data, w_if.win_ker, w_if.win_ch, w_if.win_pos, w_if.win_last};
      if (stalled) begin
        check("stall_valid", w_if.win_valid, 1'b1);
        check("stall_hold_lo", now_v[287:0], held[287:0]);
        check("stall_hold_hi", 288'(now_v[583:288]), 288'(held[583:288]));
      end
      rdy = bp ? (pat[cyc % 4] ^ ($urandom_range(0, 5) == 0)) : 1'b1;
      w_if.win_ready = rdy;
      if (w_if.win_valid && rdy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("win_data", w_if.win_data, e.data);
          check("win_ker",  w_if.win_ker,  e.ker);
          check("win_ch",   w_if.win_ch,   e.ch);
          check("win_pos",  w_if.win_pos,  e.pos);
          check("win_last", w_if.win_last, e.last);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      stalled = w_if.win_valid && !rdy;
      held    = now_v;
      cyc++;
      @(negedge clk);
    end
    check("drain_count", 32'(got), 32'(n_win));
    if (full) begin
      w_if.win_ready = 1'b0;
      check("frame_done_pulse", frame_done, 1'b1);
      check("valid_falls", w_if.win_valid, 1'b0);
      check("sb_empty", 32'(sb.size()), 32'd0);
      if (!bp) check("back_to_back", 32'(last_cyc - first_cyc + 1), 32'd48);
      @(negedge clk);
      check("frame_done_one_cycle", frame_done, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    win_t c0;
    win_t ck0;
    int   fd_before;

    rst_n = 1'b0;
    in_valid = 1'b0;
    Img = '0; Kernel = '0; Weight = '0; Opt = '0;
    w_if.win_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_win_valid",  w_if.win_valid, 1'b0);
    check("rst_win_data",   w_if.win_data,  288'd0);
    check("rst_win_ker",    w_if.win_ker,   288'd0);
    check("rst_win_chpos",  {w_if.win_ch, w_if.win_pos, w_if.win_last}, 7'd0);
    check("rst_wgt_opt",    {wgt_out, opt_out, frame_done}, 131'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic replicate run
    send_frame(32'h100, 2'b00, 0);
    c0  = {32'h105, 32'h104, 32'h104, 32'h101, 32'h100, 32'h100, 32'h101, 32'h100, 32'h100};
    for (int e = 0; e < 9; e++) ck0[e] = 32'h200 + 32'(e);
    check("basic_w0_data", w_if.win_data, c0);
    check("basic_w0_ker",  w_if.win_ker,  ck0);
    drain(1'b0, 48, 1'b1);
    check("basic_fd_count", 32'(fd_count), 32'd1);

    // Zero padding
    send_frame(32'h100, 2'b01, 0);
    drain(1'b0, 48, 1'b1);

    // Backpressure
    send_frame(32'h100, 2'b10, 0);
    drain(1'b1, 48, 1'b1);

    // Gapped input
    send_frame(32'h100, 2'b00, 5);
    drain(1'b0, 48, 1'b1);

    // Restart mid-EMIT
    send_frame(32'h100, 2'b00, 0);
    drain(1'b0, 10, 1'b0);
    fd_before = fd_count;
    sb.delete();
    send_frame(32'h500, 2'b00, 0);
    check("restart_no_frame_done", 32'(fd_count), 32'(fd_before));
    drain(1'b0, 48, 1'b1);
    check("restart_fd_count", 32'(fd_count), 32'(fd_before + 1));

    // Reset mid-EMIT
    send_frame(32'h100, 2'b01, 0);
    drain(1'b0, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_win_valid", w_if.win_valid, 1'b0);
    check("arst_win_data",  w_if.win_data,  288'd0);
    check("arst_win_ker",   w_if.win_ker,   288'd0);
    check("arst_chpos",     {w_if.win_ch, w_if.win_pos, w_if.win_last}, 7'd0);
    check("arst_wgt_opt",   {wgt_out, opt_out, frame_done}, 131'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    send_frame(32'h100, 2'b00, 0);
    drain(1'b0, 48, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
